// File: rtl/fdct2d_block_pkg.sv
// Shared constants, types and arithmetic helpers for the 8x8 forward DCT.
package jpeg_dct_pkg;

  localparam int unsigned FRAC_DEF     = 12;
  localparam int unsigned ROW_FRAC_DEF = 3;
  localparam int unsigned TW_DEF       = 18;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned COEF_W       = 12;
  localparam int unsigned ACC_W        = 40;

  typedef enum logic [1:0] {IN_ROWS, COL_PASS, OUT_HOLD} state_t;

  typedef logic [7:0][PIX_W-1:0]       pix_row_t;
  typedef logic [7:0][7:0][COEF_W-1:0] coef_blk_t;
  typedef logic signed [ACC_W-1:0]     acc_t;

  // C[k][n] = round(4096 * a(k)/2 * cos((2n+1)k*pi/16))
  localparam int COS_TBL [8][8] = '{
    '{ 1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
    '{ 2009,  1703,  1138,   400,  -400, -1138, -1703, -2009},
    '{ 1892,   784,  -784, -1892, -1892,  -784,   784,  1892},
    '{ 1703,  -400, -2009, -1138,  1138,  2009,   400, -1703},
    '{ 1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
    '{ 1138, -2009,   400,  1703, -1703,  -400,  2009, -1138},
    '{  784, -1892,  1892,  -784,  -784,  1892, -1892,   784},
    '{  400, -1138,  1703, -2009,  2009, -1703,  1138,  -400}
  };

  function automatic acc_t round_shift(input acc_t x, input int unsigned s);
    return (x + (acc_t'(1) <<< (s - 1))) >>> s;
  endfunction

  function automatic logic signed [COEF_W-1:0] sat12(input acc_t x);
    if (x > acc_t'(2047))  return 12'sh7ff;
    if (x < acc_t'(-2048)) return 12'sh800;
    return COEF_W'(x);
  endfunction

endpackage

// File: rtl/fdct2d_block_if.sv
// Row-in / block-out handshake bundle of the forward DCT.
interface fdct2d_block_if;
  import jpeg_dct_pkg::*;

  logic      valid_in;
  logic      ready_out;
  pix_row_t  row_in;
  logic [1:0] channel_in;
  coef_blk_t coef_out;
  logic [1:0] channel_out;
  logic      valid_out;
  logic      ready_in;

  modport slave (
    input  valid_in, row_in, channel_in, ready_in,
    output ready_out, coef_out, channel_out, valid_out
  );

  modport master (
    output valid_in, row_in, channel_in, ready_in,
    input  ready_out, coef_out, channel_out, valid_out
  );
endinterface

// File: rtl/fdct2d_block_fdct1d_8pt.sv
// Combinational 8-point DCT: y[k] = R(sum_n C[k][n]*x[n], SHIFT).
module fdct1d_8pt
  import jpeg_dct_pkg::*;
#(
  parameter int unsigned IW    = 9,
  parameter int unsigned SHIFT = 9,
  parameter int unsigned OW    = 18
) (
  input  logic signed [IW-1:0] x [8],
  output logic signed [OW-1:0] y [8]
);

  acc_t acc [8];

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      acc[k] = '0;
      for (int n = 0; n < 8; n++) begin
        acc[k] = acc[k] + acc_t'(x[n]) * acc_t'(COS_TBL[k][n]);
      end
      y[k] = OW'(round_shift(acc[k], SHIFT));
    end
  end

endmodule

// File: rtl/fdct2d_block.sv
// 8x8 forward DCT: row pass into a transpose buffer, column pass one column per cycle,
// then the full coefficient block is held until the quantizer takes it.
module fdct2d_block
  import jpeg_dct_pkg::*;
#(
  parameter int unsigned FRAC     = FRAC_DEF,
  parameter int unsigned ROW_FRAC = ROW_FRAC_DEF,
  parameter int unsigned TW       = TW_DEF
) (
  input logic           clk,
  input logic           rst,
  fdct2d_block_if.slave bus
);

  localparam int unsigned RIN_W = PIX_W + 1;

  state_t               state_q, state_d;
  logic [2:0]           row_cnt_q, row_cnt_d;
  logic [2:0]           col_cnt_q, col_cnt_d;
  logic signed [TW-1:0] tbuf_q [8][8];
  logic signed [TW-1:0] tbuf_d [8][8];
  coef_blk_t            coef_q, coef_d;
  logic [1:0]           channel_q, channel_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic                 accept;

  logic signed [RIN_W-1:0] row_x [8];
  logic signed [TW-1:0]    row_y [8];
  logic signed [TW-1:0]    col_x [8];
  acc_t                    col_y [8];

  assign accept = bus.valid_in & ready_q;

  // Level-shifted pixels feed the row pass; the current buffer column feeds the column pass.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      row_x[n] = $signed({1'b0, bus.row_in[n]}) - RIN_W'(128);
      col_x[n] = tbuf_q[n][col_cnt_q];
    end
  end

  fdct1d_8pt #(.IW(RIN_W), .SHIFT(FRAC - ROW_FRAC), .OW(TW)) u_row (.x(row_x), .y(row_y));
  fdct1d_8pt #(.IW(TW), .SHIFT(FRAC + ROW_FRAC), .OW(ACC_W)) u_col (.x(col_x), .y(col_y));

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    tbuf_d    = tbuf_q;
    coef_d    = coef_q;
    channel_d = channel_q;
    valid_d   = 1'b0;
    ready_d   = 1'b0;
    unique case (state_q)
      IN_ROWS: begin
        if (accept) begin
          for (int k = 0; k < 8; k++) tbuf_d[row_cnt_q][k] = row_y[k];
          if (row_cnt_q == 3'd0) channel_d = bus.channel_in;
          row_cnt_d = row_cnt_q + 3'd1;
          if (row_cnt_q == 3'd7) state_d = COL_PASS;
        end
      end
      COL_PASS: begin
        for (int k = 0; k < 8; k++) coef_d[k][col_cnt_q] = sat12(col_y[k]);
        col_cnt_d = col_cnt_q + 3'd1;
        if (col_cnt_q == 3'd7) state_d = OUT_HOLD;
      end
      OUT_HOLD: begin
        // valid_out rises one cycle after entering the hold state
        if (valid_q && bus.ready_in) state_d = IN_ROWS;
        else                         valid_d = 1'b1;
      end
      default: state_d = IN_ROWS;
    endcase
    ready_d = (state_d == IN_ROWS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IN_ROWS;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      coef_q    <= '0;
      channel_q <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) tbuf_q[r][c] <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      coef_q    <= coef_d;
      channel_q <= channel_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      tbuf_q    <= tbuf_d;
    end
  end

  assign bus.ready_out   = ready_q;
  assign bus.valid_out   = valid_q;
  assign bus.coef_out    = coef_q;
  assign bus.channel_out = channel_q;

endmodule
